vector_normalizer_seq: RTL and testbench
========================================

// Module: vector_normalizer_seq
// PURPOSE
//  Area-lean, sequential successor of the fixed 4-channel pipelined normaliser.
//  Computes y[k] = x[k] / floor(sqrt(sum_j x[j]^2)) for NUM_CHANNELS unsigned channels.
//  Uses one shared squarer/accumulator, a bit-serial integer sqrt and a restoring divider.
//  Sequencing is by FSM, with a valid/ready handshake on both sides.
//  Zero-vector detection is explicit.
// PARAMETERS
//  DATAWIDTH     8  width of each unsigned input channel (W)
//  NUM_CHANNELS  4  channel count N, >=1
//  FRAC_BITS     8  fractional bits of each quotient (F); quotient width Q = F+1
//  Derived: SW = 2*W + $clog2(N) (sum width; use 2*W when N==1), RW = (SW+1)/2 (root width)
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst      in   1      reset, asynchronous, active-high
//  i_valid  in   1      input vector valid
//  i_ready  out  1      block can accept; ==1 only in IDLE
//  i_data   in   N*W    channel k at [k*W +: W], unsigned
//  o_valid  out  1      result valid, held until accepted
//  o_ready  in   1      downstream accepts result
//  o_data   out  N*Q    quotient k at [k*Q +: Q], unsigned 1.F fixed point
//  o_root   out  RW     floor(sqrt(sum of squares))
//  o_zero   out  1      input vector was all-zero
// BEHAVIOUR
//  Reset (async): state=IDLE; o_valid=0, o_data=0, o_root=0, o_zero=0; i_ready=1.
//    Reset at any time aborts the operation in flight and loses it.
//  States: IDLE -> SQUARE -> SQRT -> DIV -> DONE -> IDLE.
//  IDLE:
//    i_valid&&i_ready registers i_data internally.
//    Later i_data changes are ignored.
//    Next state is SQUARE, or DONE if all channels == 0.
//  SQUARE: N cycles; cycle k adds x[k]*x[k] into an SW-bit accumulator (no overflow possible).
//  SQRT: RW cycles of restoring bit-serial sqrt, MSB first; produces root=floor(sqrt(sum)).
//  DIV:
//    N*(F+1) cycles; each channel gets F+1 restoring iterations.
//    q[k] = floor((x[k] << F) / root).
//    x[k] <= root guarantees q[k] <= 2^F (exactly 1.0), so Q bits never overflow.
//  DONE:
//    o_valid=1; o_data, o_root and o_zero are stable and held while o_ready=0.
//    o_valid&&o_ready -> IDLE; o_valid=0 next cycle; o_data/o_root/o_zero keep their values.
//  Zero vector: skip SQUARE/SQRT/DIV; o_data=0, o_root=0, o_zero=1; o_valid rises 1 cycle after accept.
//  Latency: o_valid rises N + RW + N*(F+1) cycles after the accept edge (defaults: 4+9+36 = 49).
//    The count is fixed and does not depend on the data.
//  Throughput: one vector per (latency + handshake) cycles; no overlap.
//    i_ready is low from accept until the cycle after the output handshake.
//  o_zero is cleared when the next nonzero result is written.
//  All arithmetic is unsigned. There is no rounding; truncation is used throughout.
// TESTING (defaults W=8, N=4, F=8)
//  1 i_data={0,0,4,3} (ch0=3) -> after 49 cycles: o_valid=1, o_root=5, q0=153, q1=204, q2=q3=0, o_zero=0
//  2 ch0=255, others 0 -> o_root=255, q0=256 (0x100 = 1.0), q1..q3=0
//  3 all channels 255 -> sum=260100, o_root=510, every q=128 (0.5)
//  4 all-zero vector -> o_valid 1 cycle after accept, o_zero=1, o_data=0, o_root=0
//  5 o_ready held low for 10 cycles in DONE -> outputs stable, i_ready=0.
//    Then i_valid toggled and i_data changed -> ignored; after o_ready=1, the next vector is accepted
//  6 assert rst mid-DIV -> outputs reset in the same cycle; i_ready=1 after release; a new vector gives correct results

Source files
------------

// File: rtl/vector_normalizer_seq.sv
// Sequential vector normaliser: y[k] = x[k] / floor(sqrt(sum x^2)).
// One shared squarer, bit-serial sqrt and restoring divider under an FSM.
module vector_normalizer_seq #(
    parameter int DATAWIDTH    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int FRAC_BITS    = 8,
    localparam int W  = DATAWIDTH,
    localparam int N  = NUM_CHANNELS,
    localparam int F  = FRAC_BITS,
    localparam int Q  = F + 1,
    localparam int SW = (N == 1) ? 2 * W : 2 * W + $clog2(N),
    localparam int RW = (SW + 1) / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [N*W-1:0]   i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [N*Q-1:0]   o_data,
    output logic [RW-1:0]    o_root,
    output logic             o_zero
);

    localparam int AW = 2 * RW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int MX = (RW > Q) ? RW : Q;
    localparam int BW = $clog2(MX + 1);

    typedef enum logic [2:0] {IDLE, SQUARE, SQRT, DIV, DONE} state_t;

    state_t state, state_nx;

    logic [N*W-1:0] x_reg;
    logic [AW-1:0]  acc;
    logic [RW-1:0]  rem;
    logic [RW-1:0]  root;
    logic [N*Q-1:0] quo;
    logic [CW-1:0]  ch_cnt;
    logic [BW-1:0]  bit_cnt;

    logic [W-1:0]   x_k;
    logic [2*W-1:0] sq;
    logic [RW+1:0]  sqrt_rem;
    logic [RW+1:0]  sqrt_try;
    logic           sqrt_ge;
    logic [RW:0]    div_rem;
    logic           div_ge;
    logic [N*Q-1:0] quo_nx;
    logic           last_ch;
    logic           last_sqrt;
    logic           last_bit;
    logic           in_zero;

    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    always_comb begin
        x_k       = x_reg[ch_cnt*W +: W];
        sq        = {{W{1'b0}}, x_k} * {{W{1'b0}}, x_k};
        sqrt_rem  = {rem, acc[AW-1 -: 2]};
        sqrt_try  = {root, 2'b01};
        sqrt_ge   = (sqrt_rem >= sqrt_try);
        // First divide step: partial remainder {x>>1, x[0]} is x itself
        div_rem   = (bit_cnt == '0) ? (RW+1)'(x_k) : {rem, 1'b0};
        div_ge    = (div_rem >= {1'b0, root});
        last_ch   = (ch_cnt == CW'(N - 1));
        last_sqrt = (bit_cnt == BW'(RW - 1));
        last_bit  = (bit_cnt == BW'(F));
        in_zero   = (i_data == '0);
        quo_nx    = quo;
        quo_nx[ch_cnt*Q +: Q] = Q'({quo[ch_cnt*Q +: Q], div_ge});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_valid) state_nx = in_zero ? DONE : SQUARE;
            SQUARE:  if (last_ch) state_nx = SQRT;
            SQRT:    if (last_sqrt) state_nx = DIV;
            DIV:     if (last_ch && last_bit) state_nx = DONE;
            DONE:    if (o_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg   <= '0;
            acc     <= '0;
            rem     <= '0;
            root    <= '0;
            quo     <= '0;
            ch_cnt  <= '0;
            bit_cnt <= '0;
            o_data  <= '0;
            o_root  <= '0;
            o_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x_reg   <= i_data;
                        acc     <= '0;
                        rem     <= '0;
                        root    <= '0;
                        ch_cnt  <= '0;
                        bit_cnt <= '0;
                        if (in_zero) begin
                            o_data <= '0;
                            o_root <= '0;
                            o_zero <= 1'b1;
                        end
                    end
                end
                SQUARE: begin
                    acc    <= acc + AW'(sq);
                    ch_cnt <= last_ch ? '0 : ch_cnt + 1'b1;
                end
                SQRT: begin
                    acc     <= acc << 2;
                    rem     <= sqrt_ge ? RW'(sqrt_rem - sqrt_try) : RW'(sqrt_rem);
                    root    <= RW'({root, sqrt_ge});
                    bit_cnt <= last_sqrt ? '0 : bit_cnt + 1'b1;
                end
                DIV: begin
                    rem <= div_ge ? RW'(div_rem - {1'b0, root}) : RW'(div_rem);
                    quo <= quo_nx;
                    if (last_bit) begin
                        bit_cnt <= '0;
                        ch_cnt  <= last_ch ? '0 : ch_cnt + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (last_bit && last_ch) begin
                        o_data <= quo_nx;
                        o_root <= root;
                        o_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_normalizer_seq.sv
// Directed bench for vector_normalizer_seq at W=8, N=4, F=8.
// Expected quotients and roots are hand-computed.
module tb_vector_normalizer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] i_data = '0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [35:0] o_data;
    logic [8:0]  o_root;
    logic        o_zero;

    int checks = 0;
    int failures = 0;

    vector_normalizer_seq dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_root  (o_root),
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;

    // Offer one vector and count clock edges after the accept until o_valid
    task automatic send(input logic [31:0] d, output int n);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = $urandom;
        n = 0;
        while (!o_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_data !== '0 ||
            o_root !== '0 || o_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset got v=%b r=%b d=%h root=%0d z=%b exp v=0 r=1 d=0 root=0 z=0",
                     o_valid, i_ready, o_data, o_root, o_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got r=%b v=%b exp r=1 v=0", i_ready, o_valid);
        end
    endtask

    task automatic test_vec(input string name, input logic [31:0] d,
                            input logic [35:0] exp_d, input logic [8:0] exp_r);
        int n;
        send(d, n);
        checks++;
        if (n !== 49) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=49", name, n);
        end
        checks++;
        if (o_data !== exp_d || o_root !== exp_r || o_zero !== 1'b0) begin
            failures++;
            $display("FAIL %s_result got d=%h root=%0d z=%b exp d=%h root=%0d z=0",
                     name, o_data, o_root, o_zero, exp_d, exp_r);
        end
        drain();
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_data !== exp_d || o_root !== exp_r) begin
            failures++;
            $display("FAIL %s_post got v=%b r=%b d=%h root=%0d exp v=0 r=1 d=%h root=%0d",
                     name, o_valid, i_ready, o_data, o_root, exp_d, exp_r);
        end
    endtask

    task automatic test_zero();
        int n;
        send(32'h0, n);
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL zero_latency got=%0d exp=0", n);
        end
        checks++;
        if (o_valid !== 1'b1 || o_zero !== 1'b1 || o_data !== '0 || o_root !== '0) begin
            failures++;
            $display("FAIL zero_result got v=%b z=%b d=%h root=%0d exp v=1 z=1 d=0 root=0",
                     o_valid, o_zero, o_data, o_root);
        end
        drain();
        checks++;
        if (o_zero !== 1'b1 || i_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_hold got z=%b r=%b exp z=1 r=1", o_zero, i_ready);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [35:0] exp_d;
        int bad;
        exp_d = {9'd0, 9'd170, 9'd170, 9'd85};
        send({8'd0, 8'd2, 8'd2, 8'd1}, n);
        checks++;
        if (n !== 49 || o_data !== exp_d || o_root !== 9'd3) begin
            failures++;
            $display("FAIL bp_result got n=%0d d=%h root=%0d exp n=49 d=%h root=3",
                     n, o_data, o_root, exp_d);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_valid = ~i_valid;
            i_data  = $urandom;
            checks++;
            if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_data !== exp_d || o_root !== 9'd3) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b r=%b d=%h root=%0d exp v=1 r=0 d=%h root=3",
                         i, o_valid, i_ready, o_data, o_root, exp_d);
            end
        end
        i_valid = 1'b0;
        drain();
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_data !== exp_d) begin
            failures++;
            $display("FAIL bp_release got v=%b r=%b d=%h exp v=0 r=1 d=%h",
                     o_valid, i_ready, o_data, exp_d);
        end
    endtask

    task automatic test_reset_mid_div();
        int n;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = {8'd255, 8'd255, 8'd255, 8'd255};
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_data !== '0 ||
            o_root !== '0 || o_zero !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got v=%b r=%b d=%h root=%0d z=%b exp all 0, r=1",
                     o_valid, i_ready, o_data, o_root, o_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_release got r=%b v=%b exp r=1 v=0", i_ready, o_valid);
        end
        n = 0;
    endtask

    initial begin
        test_reset();
        test_vec("pyth", {8'd0, 8'd0, 8'd4, 8'd3},
                 {9'd0, 9'd0, 9'd204, 9'd153}, 9'd5);
        test_vec("unit", {8'd0, 8'd0, 8'd0, 8'd255},
                 {9'd0, 9'd0, 9'd0, 9'd256}, 9'd255);
        test_vec("full", {8'd255, 8'd255, 8'd255, 8'd255},
                 {9'd128, 9'd128, 9'd128, 9'd128}, 9'd510);
        test_zero();
        test_vec("after_zero", {8'd40, 8'd30, 8'd20, 8'd10},
                 {9'd189, 9'd142, 9'd94, 9'd47}, 9'd54);
        test_backpressure();
        test_vec("back_to_back", {8'd255, 8'd255, 8'd255, 8'd255},
                 {9'd128, 9'd128, 9'd128, 9'd128}, 9'd510);
        test_reset_mid_div();
        test_vec("post_rst", {8'd40, 8'd30, 8'd20, 8'd10},
                 {9'd189, 9'd142, 9'd94, 9'd47}, 9'd54);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
